// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// instruction field positions and default reset vector.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Field positions inside a 32-bit instruction word
    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_BIT = 30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC computation: sequential (pc+4) or branch (pc+imm) target,
// plus a flag when the chosen target is not word aligned.
module instr_fetch_unit_pc_next_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic               i_pc_src,
    input  logic [INSTR_W-1:0] i_imm_ext,
    output logic [ADDR_W-1:0]  o_target,
    output logic [ADDR_W-1:0]  o_pc_plus4,
    output logic               o_misaligned
);

    // Pick the redirect target; arithmetic wraps naturally at ADDR_W bits
    always_comb begin
        o_pc_plus4   = i_pc + ADDR_W'(4);
        o_target     = i_pc_src ? (i_pc + i_imm_ext[ADDR_W-1:0]) : o_pc_plus4;
        o_misaligned = |o_target[1:0];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a
// time, holds the returned word for the control unit and advances the PC
// when the held instruction is consumed.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
)(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [6:0]         op,
    output logic [2:0]         funct3,
    output logic               funct7,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    input  logic               PCSrc,
    input  logic [INSTR_W-1:0] imm_ext,
    output logic               misalign_err,
    output logic [31:0]        instret
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_misalign;
    logic [31:0]         r_instret;

    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W-1:0]   w_pc_plus4;
    logic                w_misaligned;
    logic                w_consume;
    logic                w_rsp_accept;

    assign w_consume    = (r_state == ST_HOLD) && instr_ready;
    assign w_rsp_accept = (r_state == ST_WAIT) && imem_rsp_valid;

    instr_fetch_unit_pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .i_pc         (r_pc),
        .i_pc_src     (PCSrc),
        .i_imm_ext    (imm_ext),
        .o_target     (w_target),
        .o_pc_plus4   (w_pc_plus4),
        .o_misaligned (w_misaligned)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; HALT is only left through reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_FETCH;
            ST_FETCH: if (imem_req_ready) w_state_next = ST_WAIT;
            ST_WAIT:  if (imem_rsp_valid) w_state_next = ST_HOLD;
            ST_HOLD:  if (instr_ready) w_state_next = w_misaligned ? ST_HALT : ST_FETCH;
            ST_HALT:  w_state_next = ST_HALT;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs depend on the registered state only
    always_comb begin
        imem_req_valid = (r_state == ST_FETCH);
        instr_valid    = (r_state == ST_HOLD);
    end

    // PC, held instruction, error flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_misalign <= 1'b0;
            r_instret  <= '0;
        end else begin
            if (w_rsp_accept) begin
                r_instr <= imem_rsp_data;
            end
            if (w_consume) begin
                r_instret <= r_instret + 32'd1;
                if (w_misaligned) begin
                    r_misalign <= 1'b1;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign instr        = r_instr;
    assign op           = r_instr[OP_MSB:OP_LSB];
    assign funct3       = r_instr[F3_MSB:F3_LSB];
    assign funct7       = r_instr[F7_BIT];
    assign misalign_err = r_misalign;
    assign instret      = r_instret;

endmodule
